// File: rtl/lut_neuron_sequencer.sv
// Time-multiplexed layer of LUT neurons: accepts a vector in IDLE, evaluates one neuron per cycle,
// out_valid rises NUM_NEURONS edges after the accept edge and holds until out_ready; config only lands in IDLE.
module lut_neuron_sequencer #(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_NEURONS = 8,
  parameter int FAN_IN      = 6,
  parameter int IDX_W       = 5,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int SW = (FAN_IN > 1) ? $clog2(FAN_IN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tbl_we,
  input  logic [NW-1:0]          tbl_neuron,
  input  logic [FAN_IN-1:0]      tbl_addr,
  input  logic                   tbl_bit,
  input  logic                   map_we,
  input  logic [NW-1:0]          map_neuron,
  input  logic [SW-1:0]          map_slot,
  input  logic [IDX_W-1:0]       map_idx,
  output logic                   cfg_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  output logic                   busy
);

  localparam int VW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int TD = 1 << FAN_IN;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state, state_nx;

  logic [TD-1:0]     tbl [NUM_NEURONS];
  logic [IDX_W-1:0]  map [NUM_NEURONS][FAN_IN];
  logic [IN_WIDTH-1:0] vec;
  logic [NW-1:0]     n;
  logic [FAN_IN-1:0] addr;
  logic              lut_bit;
  logic              idle, tbl_ok, map_ok, cfg_rej;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = EVAL;
      EVAL:    if (n == NW'(NUM_NEURONS - 1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    idle      = (state == IDLE);
    in_ready  = rst_n && idle;
    out_valid = (state == DONE);
    busy      = !idle;
  end

  // Slots pointing past the input vector read as constant 0.
  for (genvar k = 0; k < FAN_IN; k++) begin : g_addr
    assign addr[k] = (32'(map[n][k]) < IN_WIDTH) ? vec[map[n][k][VW-1:0]] : 1'b0;
  end

  assign lut_bit = tbl[n][addr];

  always_comb begin
    tbl_ok  = (32'(tbl_neuron) < NUM_NEURONS);
    map_ok  = (32'(map_neuron) < NUM_NEURONS) && (32'(map_slot) < FAN_IN);
    cfg_rej = (tbl_we && (!idle || !tbl_ok)) || (map_we && (!idle || !map_ok));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        tbl[i] <= '0;
        for (int k = 0; k < FAN_IN; k++) map[i][k] <= '0;
      end
      cfg_err  <= 1'b0;
      vec      <= '0;
      n        <= '0;
      out_data <= '0;
    end else begin
      cfg_err <= cfg_rej;
      // Writes land before the next cycle, so an accept in the same cycle sees them.
      if (tbl_we && idle && tbl_ok) tbl[tbl_neuron][tbl_addr] <= tbl_bit;
      if (map_we && idle && map_ok) map[map_neuron][map_slot] <= map_idx;
      case (state)
        IDLE: if (in_valid) begin
          vec      <= in_data;
          n        <= '0;
          out_data <= '0;
        end
        EVAL: begin
          out_data[n] <= lut_bit;
          n           <= n + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
